// File: rtl/nic_rx_reader.sv
`default_nettype none
// nic_rx_reader: polls a NIC input-status register, reads each arriving packet and
// offers it to a local consumer over valid/ready, keeping rx and sequence-error counters.
module nic_rx_reader #(
  parameter int PACKET_WIDTH = 64,
  parameter int POLL_GAP     = 4,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [1:0]              addr,
  input  logic [PACKET_WIDTH-1:0] d_out,
  output logic [PACKET_WIDTH-1:0] d_in,
  output logic                    nicEn,
  output logic                    nicEnWR,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic [PACKET_WIDTH-1:0] rx_packet,
  output logic [COUNT_WIDTH-1:0]  rx_count,
  output logic [COUNT_WIDTH-1:0]  err_count,
  output logic                    busy
);

  localparam int               GAP_W      = (POLL_GAP < 1) ? 1 : $clog2(POLL_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(POLL_GAP);
  localparam logic [1:0]       ADDR_BUF   = 2'b00;
  localparam logic [1:0]       ADDR_STAT  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POLL = 3'd1,
    S_STAT = 3'd2,
    S_READ = 3'd3,
    S_CAPT = 3'd4,
    S_HOLD = 3'd5
  } state_t;

  state_t                  state_q;
  logic [GAP_W-1:0]        gap_q;
  logic [31:0]             seq_q;
  logic [31:0]             seq_d;
  logic                    nicEn_q;
  logic [1:0]              addr_q;
  logic                    rx_valid_q;
  logic                    busy_q;
  logic [PACKET_WIDTH-1:0] rx_packet_q;
  logic [COUNT_WIDTH-1:0]  rx_count_q;
  logic [COUNT_WIDTH-1:0]  err_count_q;
  logic [COUNT_WIDTH-1:0]  err_count_d;

  // After any capture, matched or not, the sequence resyncs to the received value + 1.
  always_comb begin
    seq_d       = d_out[31:0] + 32'd1;
    err_count_d = err_count_q;
    if ((d_out[31:0] != seq_q) && (err_count_q != {COUNT_WIDTH{1'b1}})) begin
      err_count_d = err_count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      gap_q       <= '0;
      seq_q       <= '0;
      nicEn_q     <= 1'b0;
      addr_q      <= ADDR_STAT;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      rx_packet_q <= '0;
      rx_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gap_q <= GAP_W'(1)) begin
            gap_q   <= '0;
            state_q <= S_POLL;
            nicEn_q <= 1'b1;
            addr_q  <= ADDR_STAT;
            busy_q  <= 1'b1;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        S_POLL: begin
          state_q <= S_STAT;
          nicEn_q <= 1'b0;
          addr_q  <= ADDR_STAT;
        end
        S_STAT: begin
          if (d_out[0]) begin
            state_q <= S_READ;
            nicEn_q <= 1'b1;
            addr_q  <= ADDR_BUF;
          end else if (POLL_GAP == 0) begin
            state_q <= S_POLL;
            nicEn_q <= 1'b1;
            addr_q  <= ADDR_STAT;
          end else begin
            state_q <= S_IDLE;
            gap_q   <= GAP_RELOAD;
            busy_q  <= 1'b0;
          end
        end
        S_READ: begin
          state_q <= S_CAPT;
          nicEn_q <= 1'b0;
          addr_q  <= ADDR_STAT;
        end
        S_CAPT: begin
          rx_packet_q <= d_out;
          err_count_q <= err_count_d;
          seq_q       <= seq_d;
          rx_valid_q  <= 1'b1;
          state_q     <= S_HOLD;
        end
        S_HOLD: begin
          // No bus access here: the NIC buffer stays full and the network stalls.
          if (rx_ready) begin
            rx_valid_q <= 1'b0;
            rx_count_q <= rx_count_q + COUNT_WIDTH'(1);
            state_q    <= S_POLL;
            nicEn_q    <= 1'b1;
            addr_q     <= ADDR_STAT;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          gap_q      <= '0;
          nicEn_q    <= 1'b0;
          addr_q     <= ADDR_STAT;
          rx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign addr      = addr_q;
  assign d_in      = '0;
  assign nicEn     = nicEn_q;
  assign nicEnWR   = 1'b0;
  assign rx_valid  = rx_valid_q;
  assign rx_packet = rx_packet_q;
  assign rx_count  = rx_count_q;
  assign err_count = err_count_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_nic_rx_reader.sv
`default_nettype none
// tb_nic_rx_reader: two reader instances, each beside a small NIC model, with a
// scoreboard of expected packets checked whenever the consumer accepts one.
module tb_nic_rx_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] data;
    logic [15:0] err;
  } exp_t;

  // ---------------- instance A: 64-bit, POLL_GAP=4, 16-bit counters
  logic        rst_a_n = 1'b0;
  logic        rx_ready_a = 1'b0;
  logic [1:0]  addr_a;
  logic [63:0] d_out_a = '0;
  logic [63:0] d_in_a;
  logic        nicEn_a, nicEnWR_a, rx_valid_a, busy_a;
  logic [63:0] rx_packet_a;
  logic [15:0] rx_count_a, err_count_a;

  nic_rx_reader #(.PACKET_WIDTH(64), .POLL_GAP(4), .COUNT_WIDTH(16)) u_dut_a (
    .clk(clk), .reset(rst_a_n), .addr(addr_a), .d_out(d_out_a), .d_in(d_in_a),
    .nicEn(nicEn_a), .nicEnWR(nicEnWR_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .rx_packet(rx_packet_a), .rx_count(rx_count_a), .err_count(err_count_a), .busy(busy_a)
  );

  // ---------------- instance B: 32-bit, POLL_GAP=0, 2-bit counters
  logic        rst_b_n = 1'b0;
  logic        rx_ready_b = 1'b1;
  logic [1:0]  addr_b;
  logic [31:0] d_out_b = '0;
  logic [31:0] d_in_b;
  logic        nicEn_b, nicEnWR_b, rx_valid_b, busy_b;
  logic [31:0] rx_packet_b;
  logic [1:0]  rx_count_b, err_count_b;

  nic_rx_reader #(.PACKET_WIDTH(32), .POLL_GAP(0), .COUNT_WIDTH(2)) u_dut_b (
    .clk(clk), .reset(rst_b_n), .addr(addr_b), .d_out(d_out_b), .d_in(d_in_b),
    .nicEn(nicEn_b), .nicEnWR(nicEnWR_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .rx_packet(rx_packet_b), .rx_count(rx_count_b), .err_count(err_count_b), .busy(busy_b)
  );

  // ---------------- NIC models: pending packets are mem[rd..wr-1]; status bit 0 = nonempty
  logic [63:0] mem_a [0:15];
  logic [31:0] mem_b [0:15];
  int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;

  always @(posedge clk) begin
    if (nicEn_a && !nicEnWR_a) begin
      if (addr_a == 2'b01) d_out_a <= {63'b0, (wr_a != rd_a)};
      else if (addr_a == 2'b00) begin
        d_out_a <= mem_a[rd_a[3:0]];
        if (wr_a != rd_a) rd_a <= rd_a + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (nicEn_b && !nicEnWR_b) begin
      if (addr_b == 2'b01) d_out_b <= {31'b0, (wr_b != rd_b)};
      else if (addr_b == 2'b00) begin
        d_out_b <= mem_b[rd_b[3:0]];
        if (wr_b != rd_b) rd_b <= rd_b + 1;
      end
    end
  end

  // ---------------- scoreboards
  exp_t q_a[$];
  exp_t q_b[$];
  int acc_a = 0, acc_b = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  task automatic push_a(input logic [63:0] data, input logic [15:0] err);
    exp_t e;
    e.data = data;
    e.err  = err;
    mem_a[wr_a[3:0]] = data;
    q_a.push_back(e);
    wr_a = wr_a + 1;
  endtask

  task automatic push_b(input logic [31:0] data, input logic [15:0] err);
    exp_t e;
    e.data = 64'(data);
    e.err  = err;
    mem_b[wr_b[3:0]] = data;
    q_b.push_back(e);
    wr_b = wr_b + 1;
  endtask

  always @(negedge clk) begin
    if (!rst_a_n) begin
      acc_a = 0;
      q_a.delete();
    end else if (rx_valid_a && rx_ready_a) begin
      if (q_a.size() == 0) fail_now("sb_a_unexpected_packet");
      else begin
        exp_t e;
        e = q_a.pop_front();
        check("sb_a_packet", rx_packet_a, e.data);
        check("sb_a_err_count", 64'(err_count_a), 64'(e.err));
        check("sb_a_rx_count", 64'(rx_count_a), 64'(acc_a % 65536));
        acc_a = acc_a + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_b_n) begin
      acc_b = 0;
      q_b.delete();
    end else if (rx_valid_b && rx_ready_b) begin
      if (q_b.size() == 0) fail_now("sb_b_unexpected_packet");
      else begin
        exp_t e;
        e = q_b.pop_front();
        check("sb_b_packet", 64'(rx_packet_b), e.data);
        check("sb_b_err_count", 64'(err_count_b), 64'(e.err));
        check("sb_b_rx_count", 64'(rx_count_b), 64'(acc_b % 4));
        acc_b = acc_b + 1;
      end
    end
  end

  // ---------------- helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_nicEn"},     64'(nicEn_a),     64'd0);
    check({tag, "_nicEnWR"},   64'(nicEnWR_a),   64'd0);
    check({tag, "_addr"},      64'(addr_a),      64'd1);
    check({tag, "_d_in"},      d_in_a,           64'd0);
    check({tag, "_rx_valid"},  64'(rx_valid_a),  64'd0);
    check({tag, "_rx_packet"}, rx_packet_a,      64'd0);
    check({tag, "_rx_count"},  64'(rx_count_a),  64'd0);
    check({tag, "_err_count"}, 64'(err_count_a), 64'd0);
    check({tag, "_busy"},      64'(busy_a),      64'd0);
  endtask

  task automatic wait_valid_a(input string nm, input int bound);
    int n = 0;
    while (!rx_valid_a && n < bound) begin
      smp();
      n++;
    end
    if (!rx_valid_a) fail_now(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus
  initial begin
    // Reset values at power-up
    smp();
    check_reset_a("por");

    // Instance B: five mismatching packets; err saturates at 3, rx_count wraps to 1
    step();
    rst_b_n = 1'b1;
    push_b(32'd10, 16'd1);
    push_b(32'd20, 16'd2);
    push_b(32'd30, 16'd3);
    push_b(32'd40, 16'd3);
    push_b(32'd50, 16'd3);

    // Empty polling: nicEn pulses every 6 cycles, addr never leaves 01
    rst_a_n = 1'b1;
    smp();
    smp();
    check("first_poll_nicEn", 64'(nicEn_a), 64'd1);
    check("first_poll_addr", 64'(addr_a), 64'd1);
    for (int c = 1; c < 24; c++) begin
      smp();
      check($sformatf("empty_poll_nicEn_c%0d", c), 64'(nicEn_a), 64'((c % 6) == 0));
      check($sformatf("empty_poll_addr_c%0d", c), 64'(addr_a), 64'd1);
    end

    // Single receive: packet 0 present at the first poll, consumer always ready
    step();
    rst_a_n = 1'b0;
    smp();
    step();
    push_a(64'h0, 16'd0);
    rst_a_n    = 1'b1;
    rx_ready_a = 1'b1;
    smp();
    smp();
    check("rcv_poll_nicEn", 64'(nicEn_a), 64'd1);
    check("rcv_poll_addr", 64'(addr_a), 64'd1);
    smp();
    check("rcv_stat_valid", 64'(rx_valid_a), 64'd0);
    smp();
    check("rcv_read_nicEn", 64'(nicEn_a), 64'd1);
    check("rcv_read_addr", 64'(addr_a), 64'd0);
    smp();
    check("rcv_capt_valid", 64'(rx_valid_a), 64'd0);
    smp();
    check("rcv_hold_valid", 64'(rx_valid_a), 64'd1);
    smp();
    check("rcv_after_valid", 64'(rx_valid_a), 64'd0);
    check("rcv_after_poll", 64'(nicEn_a), 64'd1);
    check("rcv_rx_count", 64'(rx_count_a), 64'd1);
    check("rcv_err_count", 64'(err_count_a), 64'd0);

    // Backpressure: packet 1 held 20 cycles with no bus activity
    step();
    rx_ready_a = 1'b0;
    push_a(64'h1, 16'd0);
    wait_valid_a("bp_wait_valid", 60);
    for (int c = 0; c < 20; c++) begin
      smp();
      check("bp_valid_held", 64'(rx_valid_a), 64'd1);
      check("bp_no_nicEn", 64'(nicEn_a), 64'd0);
      check("bp_packet_held", rx_packet_a, 64'h1);
    end
    step();
    rx_ready_a = 1'b1;
    smp();
    smp();
    check("bp_release_valid", 64'(rx_valid_a), 64'd0);
    check("bp_release_poll", 64'(nicEn_a), 64'd1);
    check("bp_rx_count", 64'(rx_count_a), 64'd2);
    check("bp_packet_kept", rx_packet_a, 64'h1);

    // Sequence error: 5 mismatches (expected 2), 6 then matches
    step();
    push_a(64'h5, 16'd1);
    push_a(64'h6, 16'd1);
    begin
      int n = 0;
      while (acc_a < 4 && n < 100) begin
        smp();
        n++;
      end
      if (acc_a < 4) fail_now("seq_wait_packets");
    end
    smp();
    check("seq_rx_count", 64'(rx_count_a), 64'd4);
    check("seq_err_count", 64'(err_count_a), 64'd1);

    // Reset mid-HOLD: outputs clear without a clock edge, pending packet discarded
    step();
    rx_ready_a = 1'b0;
    push_a(64'h7, 16'd1);
    wait_valid_a("rst_wait_hold", 60);
    check("rst_hold_packet", rx_packet_a, 64'h7);
    #2;
    rst_a_n = 1'b0;
    #1;
    check_reset_a("async_rst");
    smp();
    step();
    rst_a_n = 1'b1;
    smp();
    check("rst_rel_idle_nicEn", 64'(nicEn_a), 64'd0);
    smp();
    check("rst_rel_poll_nicEn", 64'(nicEn_a), 64'd1);
    check("rst_rel_poll_addr", 64'(addr_a), 64'd1);
    check("rst_rel_rx_valid", 64'(rx_valid_a), 64'd0);

    // Instance B completion
    begin
      int n = 0;
      while (acc_b < 5 && n < 200) begin
        smp();
        n++;
      end
      if (acc_b < 5) fail_now("sat_wait_packets");
    end
    smp();
    check("sat_err_count", 64'(err_count_b), 64'd3);
    check("wrap_rx_count", 64'(rx_count_b), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
